// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle MIPS program-counter owner: fetches one instruction, waits for execute, then picks the next PC.
// Optional alignment fault redirect is enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        exec_done,
    input  logic [1:0]  next_sel,
    input  logic [31:0] branch_off,
    input  logic [25:0] jump_index,
    input  logic [31:0] epc,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ir_q;
    logic [31:0] next_pc;
    logic        imem_req_q;
    logic        ir_valid_q;
    logic        halted_q;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        unique case (next_sel)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = pc_plus4 + branch_off;
            2'b10: next_pc = {pc_plus4[31:28], jump_index, 2'b00};
            2'b11: next_pc = epc;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;
    logic fault_q;

    assign misaligned = (next_pc[1:0] != 2'b00);
    assign pc_d       = misaligned ? EXC_VECTOR : next_pc;
    assign fault      = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_q == S_EXEC) && exec_done && misaligned;
        end
    end
`else
    logic [31:0] unused_exc_vector;

    assign unused_exc_vector = EXC_VECTOR;
    assign pc_d              = next_pc;
    assign fault             = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // Ack is only honoured once the request is visibly high, so a stale ack right after reset is dropped.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        ir_valid_q <= 1'b1;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        pc_q       <= pc_d;
                        ir_valid_q <= 1'b0;
                        if (halt) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    imem_req_q <= 1'b0;
                    ir_valid_q <= 1'b0;
                    halted_q   <= 1'b1;
                end
                default: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b0;
                    ir_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: fetch handshake, next-PC selection, stalls, async reset, wrap and halt.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        ir_valid;
    logic        exec_done = 1'b0;
    logic [1:0]  next_sel = 2'b00;
    logic [31:0] branch_off = '0;
    logic [25:0] jump_index = '0;
    logic [31:0] epc = '0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_mis_pc;
    logic        exp_mis_fault;

    pc_fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .EXC_VECTOR(EXC_VECTOR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .exec_done (exec_done),
        .next_sel  (next_sel),
        .branch_off(branch_off),
        .jump_index(jump_index),
        .epc       (epc),
        .halt      (halt),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that captured the instruction.
    task automatic do_fetch(input logic [31:0] word, input int stall, input logic [31:0] exp_addr);
        int guard = 0;
        while (!imem_req && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("req_seen", {31'd0, imem_req}, 32'd1);
        check_val("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_val("stall_req", {31'd0, imem_req}, 32'd1);
            check_val("stall_addr", imem_addr, exp_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        check_val("ir", ir, word);
        check_val("ir_valid_set", {31'd0, ir_valid}, 32'd1);
        check_val("req_drop", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic do_exec(input logic [1:0] sel, input logic [31:0] off, input logic [25:0] idx,
                           input logic [31:0] e, input logic h,
                           input logic [31:0] exp_pc, input logic exp_fault);
        next_sel   = sel;
        branch_off = off;
        jump_index = idx;
        epc        = e;
        halt       = h;
        exec_done  = 1'b1;
        @(posedge clk); #1;
        exec_done = 1'b0;
        halt      = 1'b0;
        check_val("next_pc", pc, exp_pc);
        check_val("ir_valid_clr", {31'd0, ir_valid}, 32'd0);
        check_val("req_after_exec", {31'd0, imem_req}, {31'd0, ~h});
        check_val("halted", {31'd0, halted}, {31'd0, h});
        check_val("fault", {31'd0, fault}, {31'd0, exp_fault});
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_req_async", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        check_val("rst_pc", pc, RESET_PC);
        check_val("rst_ir", ir, 32'd0);
        check_val("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check_val("rst_halted", {31'd0, halted}, 32'd0);
        check_val("rst_fault", {31'd0, fault}, 32'd0);
        check_val("rst_pc_plus4", pc_plus4, 32'h0040_0004);
        rst_n = 1'b1;
        check_val("req_low_before_edge", {31'd0, imem_req}, 32'd0);

        // Sequential flow
        do_fetch(32'h2008_0005, 1, 32'h0040_0000);
        do_exec(2'b00, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0040_0004, 1'b0);
        check_val("seq_addr", imem_addr, 32'h0040_0004);

        // Branches
        do_fetch(32'h1111_0001, 0, 32'h0040_0004);
        do_exec(2'b11, 32'd0, 26'd0, 32'h0040_0010, 1'b0, 32'h0040_0010, 1'b0);
        do_fetch(32'h1111_0002, 0, 32'h0040_0010);
        do_exec(2'b01, 32'hFFFF_FFF0, 26'd0, 32'd0, 1'b0, 32'h0040_0004, 1'b0);
        do_fetch(32'h1111_0003, 0, 32'h0040_0004);
        do_exec(2'b01, 32'h0000_0100, 26'd0, 32'd0, 1'b0, 32'h0040_0108, 1'b0);

        // Jump and exception return
        do_fetch(32'h1111_0004, 2, 32'h0040_0108);
        do_exec(2'b11, 32'd0, 26'd0, 32'h0040_0020, 1'b0, 32'h0040_0020, 1'b0);
        do_fetch(32'h0810_0003, 0, 32'h0040_0020);
        do_exec(2'b10, 32'd0, 26'h010_0003, 32'd0, 1'b0, 32'h0040_000C, 1'b0);
        do_fetch(32'h4200_0018, 0, 32'h0040_000C);
        do_exec(2'b11, 32'd0, 26'd0, 32'h0040_0200, 1'b0, 32'h0040_0200, 1'b0);

        // Misaligned exception return
`ifdef PC_ALIGN_CHECK_EN
        exp_mis_pc    = EXC_VECTOR;
        exp_mis_fault = 1'b1;
`else
        exp_mis_pc    = 32'h0040_0102;
        exp_mis_fault = 1'b0;
`endif
        do_fetch(32'h4200_0018, 0, 32'h0040_0200);
        do_exec(2'b11, 32'd0, 26'd0, 32'h0040_0102, 1'b0, exp_mis_pc, exp_mis_fault);
        @(posedge clk); #1;
        check_val("fault_one_cycle", {31'd0, fault}, 32'd0);

        // Stalled fetch with stray exec_done, then async reset mid-wait
        check_val("stall_req0", {31'd0, imem_req}, 32'd1);
        exec_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("stall5_req", {31'd0, imem_req}, 32'd1);
            check_val("stall5_addr", imem_addr, exp_mis_pc);
            check_val("stall5_pc", pc, exp_mis_pc);
            check_val("stall5_ir_valid", {31'd0, ir_valid}, 32'd0);
        end
        exec_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("midwait_req_async", {31'd0, imem_req}, 32'd0);
        check_val("midwait_pc_async", pc, RESET_PC);
        check_val("midwait_ir_async", ir, 32'd0);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst_n      = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        check_val("stale_ack_ir_valid", {31'd0, ir_valid}, 32'd0);
        check_val("stale_ack_ir", ir, 32'd0);
        check_val("post_rst_req", {31'd0, imem_req}, 32'd1);

        // PC wrap, then halt
        do_fetch(32'h1111_0005, 0, RESET_PC);
        do_exec(2'b11, 32'd0, 26'd0, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0);
        check_val("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        do_fetch(32'h1111_0006, 0, 32'hFFFF_FFFC);
        do_exec(2'b00, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_0000, 1'b0);
        do_fetch(32'h0000_000D, 0, 32'h0000_0000);
        do_exec(2'b00, 32'd0, 26'd0, 32'd0, 1'b1, 32'h0000_0004, 1'b0);
        for (int i = 0; i < 12; i++) begin
            imem_ack  = i[0];
            exec_done = ~i[0];
            @(posedge clk); #1;
            check_val("halt_req", {31'd0, imem_req}, 32'd0);
            check_val("halt_flag", {31'd0, halted}, 32'd1);
            check_val("halt_pc", pc, 32'h0000_0004);
            check_val("halt_ir_valid", {31'd0, ir_valid}, 32'd0);
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
